filter_driver: RTL and testbench

Host-side driver for the FIR filter's configuration and sample ports.
- Takes a 64-bit coefficient/mask word and serialises it into eight byte writes on the filter's CPU write port (w_en_n, p, addr).
- Buffers incoming samples in a small FIFO and issues them on the filter's sample port (x_valid_n, x).
- Holds samples back while a configuration load is in progress, so the filter never sees a write and a sample in the same cycle.

---
 rtl/filter_driver_if.sv | 26 ++
 rtl/filter_driver.sv | 160 ++++++++++++++++
 tb/tb_filter_driver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/filter_driver_if.sv
// Host-side bundle between a producer, the filter_driver and the FIR filter:
// config request, sample stream in, and the filter's write/sample ports out.
interface filter_driver_if;
    logic        cfg_start;
    logic [63:0] cfg_param;
    logic        cfg_busy;
    logic        cfg_done;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        w_en_n;
    logic [7:0]  p;
    logic [15:0] addr;
    logic        x_valid_n;
    logic [7:0]  x;

    modport master (
        input  cfg_start, cfg_param, s_valid, s_data,
        output cfg_busy, cfg_done, s_ready, w_en_n, p, addr, x_valid_n, x
    );

    modport slave (
        output cfg_start, cfg_param, s_valid, s_data,
        input  cfg_busy, cfg_done, s_ready, w_en_n, p, addr, x_valid_n, x
    );
endinterface

// File: rtl/filter_driver.sv
// Serialises a 64-bit coefficient/mask word into eight filter byte writes and
// feeds buffered samples to the filter only while no configuration load runs.
module filter_driver #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          WR_GAP    = 1,
    parameter int          DEPTH     = 4
) (
    input  logic            clock,
    input  logic            rst_n,
    filter_driver_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST  = (WR_GAP > 0) ? GW'(WR_GAP - 1) : '0;
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    state_t         state_q, state_d;
    logic [2:0]     k_q, k_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [63:0]    shadow_q, shadow_d;
    logic           w_en_n_q, w_en_n_d;
    logic [7:0]     p_q, p_d;
    logic [15:0]    addr_q, addr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           x_valid_n_q, x_valid_n_d;
    logic [7:0]     x_q, x_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [7:0]     fifo_mem [DEPTH];

    logic           s_ready_w;
    logic           push;
    logic           pop;

    assign s_ready_w = rst_n && (count_q < DEPTH_CNT);
    assign push      = bus.s_valid && s_ready_w;
    // A start request in IDLE takes priority over issuing a sample that cycle.
    assign pop       = (state_q == IDLE) && !bus.cfg_start && (count_q != '0);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        gap_d    = gap_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (bus.cfg_start) begin
                    shadow_d = bus.cfg_param;
                    k_d      = 3'd0;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (k_q == 3'd7) begin
                    state_d = IDLE;
                end else if (WR_GAP > 0) begin
                    gap_d   = GAP_LAST;
                    state_d = GAP;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    k_d     = k_q + 3'd1;
                    state_d = WRITE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state.
    always_comb begin
        w_en_n_d = (state_d != WRITE);
        p_d      = p_q;
        addr_d   = addr_q;
        if (state_d == WRITE) begin
            addr_d = BASE_ADDR + {13'd0, k_d};
            p_d    = shadow_d[{k_d, 3'b000} +: 8];
        end
        busy_d      = (state_d != IDLE);
        done_d      = (state_q == WRITE) && (k_q == 3'd7);
        x_valid_n_d = !pop;
        x_d         = pop ? fifo_mem[rd_ptr_q] : x_q;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= 3'd0;
            gap_q       <= '0;
            shadow_q    <= '0;
            w_en_n_q    <= 1'b1;
            p_q         <= 8'd0;
            addr_q      <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            x_valid_n_q <= 1'b1;
            x_q         <= 8'd0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            gap_q       <= gap_d;
            shadow_q    <= shadow_d;
            w_en_n_q    <= w_en_n_d;
            p_q         <= p_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            x_valid_n_q <= x_valid_n_d;
            x_q         <= x_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // Sample storage is not reset; emptiness is tracked by the pointers/count.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.s_data;
        end
    end

    assign bus.s_ready   = s_ready_w;
    assign bus.w_en_n    = w_en_n_q;
    assign bus.p         = p_q;
    assign bus.addr      = addr_q;
    assign bus.cfg_busy  = busy_q;
    assign bus.cfg_done  = done_q;
    assign bus.x_valid_n = x_valid_n_q;
    assign bus.x         = x_q;
endmodule

// File: tb/tb_filter_driver.sv
// Scoreboard bench for filter_driver: two instances (gapped and back-to-back
// writes) share stimulus; each has its own reference model and monitor.
module tb_filter_driver;
    localparam int DEPTH = 4;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  p;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } smp_t;

    bit          clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [63:0] cfg_param = '0;
    logic        s_valid = 1'b1;
    logic [7:0]  s_data = 8'hA5;
    int          checks = 0;
    int          errors = 0;
    bit          end_of_test = 1'b0;

    always #5 clock = ~clock;

    task automatic chk(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst%0d actual=%0h required=%0h", name, inst, act, req);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int          G = (gi == 0) ? 1 : 0;
        localparam logic [15:0] B = (gi == 0) ? 16'h0000 : 16'hFFFC;

        filter_driver_if bus ();

        assign bus.cfg_start = cfg_start;
        assign bus.cfg_param = cfg_param;
        assign bus.s_valid   = s_valid;
        assign bus.s_data    = s_data;

        filter_driver #(.BASE_ADDR(B), .WR_GAP(G), .DEPTH(DEPTH)) dut (
            .clock (clock),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // Model state: a load occupies cycles lf..ll, cfg_done is cycle dc.
        int          cyc = 0;
        int          lf = -10;
        int          ll = -20;
        int          dc = -1;
        int          rst_cyc = -1;
        bit          exp_busy = 1'b0;
        bit          exp_done = 1'b0;
        bit          exp_ready = 1'b0;
        logic [7:0]  fifo_m [$];
        wr_t         wq [$];
        smp_t        sq [$];
        logic [15:0] last_addr = '0;
        logic [7:0]  last_p = '0;
        logic [7:0]  last_x = '0;

        always @(posedge clock) begin : model
            int   e;
            bit   idle;
            bit   pop;
            bit   push;
            wr_t  w;
            smp_t s;
            e = cyc;
            if (!rst_n) begin
                fifo_m.delete();
                while (wq.size() > 0 && wq[wq.size()-1].cyc > e) void'(wq.pop_back());
                lf = -10;
                ll = -20;
                dc = -1;
                rst_cyc = e + 1;
            end else begin
                idle = !(e >= lf && e <= ll);
                pop  = idle && !cfg_start && (fifo_m.size() > 0);
                push = s_valid && (fifo_m.size() < DEPTH);
                if (idle && cfg_start) begin
                    lf = e + 1;
                    ll = e + 1 + 7 * (G + 1);
                    dc = ll + 1;
                    for (int k = 0; k < 8; k++) begin
                        w.cyc  = e + 1 + k * (G + 1);
                        w.addr = B + 16'(k);
                        w.p    = cfg_param[8*k +: 8];
                        wq.push_back(w);
                    end
                end
                if (pop) begin
                    s.cyc = e + 1;
                    s.d   = fifo_m.pop_front();
                    sq.push_back(s);
                end
                if (push) fifo_m.push_back(s_data);
            end
            cyc       = e + 1;
            exp_busy  = (cyc >= lf) && (cyc <= ll);
            exp_done  = (cyc == dc);
            exp_ready = rst_n && (fifo_m.size() < DEPTH);
        end

        always @(negedge clock) begin : monitor
            bit   exp_w;
            bit   exp_x;
            wr_t  w;
            smp_t s;
            if (cyc >= 1) begin
                if (cyc == rst_cyc) begin
                    last_addr = '0;
                    last_p    = '0;
                    last_x    = '0;
                end
                exp_w = (wq.size() > 0) && (wq[0].cyc == cyc);
                chk("w_en_n", gi, 64'(bus.w_en_n), 64'(!exp_w));
                if (exp_w) begin
                    w = wq.pop_front();
                    last_addr = w.addr;
                    last_p    = w.p;
                    $display("inst%0d cyc %0d write addr=%h p=%h", gi, cyc, bus.addr, bus.p);
                end
                chk("addr", gi, 64'(bus.addr), 64'(last_addr));
                chk("p", gi, 64'(bus.p), 64'(last_p));

                exp_x = (sq.size() > 0) && (sq[0].cyc == cyc);
                chk("x_valid_n", gi, 64'(bus.x_valid_n), 64'(!exp_x));
                if (exp_x) begin
                    s = sq.pop_front();
                    last_x = s.d;
                    $display("inst%0d cyc %0d sample x=%h", gi, cyc, bus.x);
                end
                chk("x", gi, 64'(bus.x), 64'(last_x));

                chk("cfg_busy", gi, 64'(bus.cfg_busy), 64'(exp_busy));
                chk("cfg_done", gi, 64'(bus.cfg_done), 64'(exp_done));
                chk("s_ready", gi, 64'(bus.s_ready), 64'(exp_ready));
                chk("wr_and_sample", gi, 64'(!bus.w_en_n && !bus.x_valid_n), 64'(0));
            end
        end

        initial begin
            wait (end_of_test);
            chk("writes_outstanding", gi, 64'(wq.size()), 64'(0));
            chk("samples_outstanding", gi, 64'(sq.size()), 64'(0));
        end
    end

    task automatic drive(input logic st, input logic [63:0] prm, input logic v,
                         input logic [7:0] d, input logic rn);
        @(negedge clock);
        #1;
        cfg_start = st;
        cfg_param = prm;
        s_valid   = v;
        s_data    = d;
        rst_n     = rn;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 1'b0, 8'd0, 1'b1);
    endtask

    initial begin
        // Reset with s_valid held high: nothing may be pushed.
        drive(1'b0, 64'd0, 1'b1, 8'h5A, 1'b0);
        idle(3);

        // Single load with samples arriving mid-load.
        drive(1'b1, 64'hFF07060504030201, 1'b0, 8'd0, 1'b1);
        idle(1);
        drive(1'b0, 64'd0, 1'b1, 8'h10, 1'b1);
        drive(1'b0, 64'd0, 1'b1, 8'h20, 1'b1);
        drive(1'b0, 64'd0, 1'b1, 8'h30, 1'b1);
        idle(20);

        // Backpressure: six back-to-back samples during a load.
        drive(1'b1, 64'h8877665544332211, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b0, 64'd0, 1'b1, 8'(8'h41 + i), 1'b1);
        idle(20);

        // A second start during a load is ignored.
        drive(1'b1, 64'h0123456789ABCDEF, 1'b0, 8'd0, 1'b1);
        idle(2);
        drive(1'b1, 64'hDEADBEEFCAFEF00D, 1'b0, 8'd0, 1'b1);
        idle(20);

        // Reset during the byte-3 write of the gapped instance.
        drive(1'b1, 64'h1122334455667788, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 64'd0, 1'b1, 8'(8'h70 + i), 1'b1);
        idle(3);
        drive(1'b0, 64'd0, 1'b1, 8'h99, 1'b0);
        idle(2);
        drive(1'b1, 64'hA1A2A3A4A5A6A7A8, 1'b0, 8'd0, 1'b1);
        idle(20);

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 29) == 0), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 199) != 0));
        end
        idle(40);

        end_of_test = 1'b1;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
